// File: rtl/stream_window_gen.sv
// rtl/stream_window_gen.sv - raster-order KxK sliding-window generator between two FIFOs
// WINDOW_REPLICATE_EN: out-of-frame taps replicate the nearest edge pixel instead of reading zero
module stream_window_gen #(
  parameter int WIDTH      = 720,
  parameter int HEIGHT     = 540,
  parameter int DATA_WIDTH = 8,
  parameter int KSIZE      = 3
) (
  input  logic                                clock,
  input  logic                                reset,
  output logic                                in_rd_en,
  input  logic                                in_empty,
  input  logic [DATA_WIDTH-1:0]               in_dout,
  output logic                                out_wr_en,
  input  logic                                out_full,
  output logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   out_din
);

  localparam int H      = (KSIZE - 1) / 2;
  localparam int LAG    = H * WIDTH + H;
  localparam int SR_LEN = 2 * LAG + 1;
  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int CW     = $clog2(NPIX + 1);
  localparam int SIW    = $clog2(SR_LEN);

  localparam logic [CW-1:0] LAST_COL  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_ROW  = CW'(HEIGHT - 1);
  localparam logic [CW-1:0] LAST_READ = CW'(NPIX - 1);
  localparam logic [CW-1:0] FILL_LAST = CW'(LAG);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t                  state;
  logic [CW-1:0]           in_count;
  logic [CW-1:0]           out_row;
  logic [CW-1:0]           out_col;
  logic [DATA_WIDTH-1:0]   sr [SR_LEN];
  logic                    step;
  int                      r_i;
  int                      c_i;

  always_comb begin
    step = 1'b0;
    case (state)
      FILL:    step = !in_empty;
      RUN:     step = !in_empty && !out_full;
      FLUSH:   step = !out_full;
      default: step = 1'b0;
    endcase
  end

  assign in_rd_en  = !reset && step && (state != FLUSH);
  assign out_wr_en = !reset && step && (state != FILL);

  assign r_i = int'(out_row);
  assign c_i = int'(out_col);

  // sr[0] is the newest pixel; the centre pixel of the current output sits at sr[LAG].
  for (genvar i = 0; i < KSIZE; i++) begin : g_row
    for (genvar j = 0; j < KSIZE; j++) begin : g_col
      localparam int DR = i - H;
      localparam int DC = j - H;
      localparam int K  = i * KSIZE + j;
`ifdef WINDOW_REPLICATE_EN
      int               rt;
      int               ct;
      logic [SIW-1:0]   sidx;
      always_comb begin
        rt = r_i + DR;
        ct = c_i + DC;
        if (rt < 0) rt = 0;
        else if (rt > HEIGHT - 1) rt = HEIGHT - 1;
        if (ct < 0) ct = 0;
        else if (ct > WIDTH - 1) ct = WIDTH - 1;
        sidx = SIW'(LAG - ((rt - r_i) * WIDTH + (ct - c_i)));
      end
      assign out_din[K*DATA_WIDTH +: DATA_WIDTH] = sr[sidx];
`else
      localparam int SI = LAG - DR * WIDTH - DC;
      logic in_frame;
      assign in_frame = (r_i + DR >= 0) && (r_i + DR < HEIGHT) &&
                        (c_i + DC >= 0) && (c_i + DC < WIDTH);
      assign out_din[K*DATA_WIDTH +: DATA_WIDTH] = in_frame ? sr[SI] : '0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= FILL;
      in_count <= '0;
      out_row  <= '0;
      out_col  <= '0;
      for (int i = 0; i < SR_LEN; i++) sr[i] <= '0;
    end else if (step) begin
      for (int i = SR_LEN - 1; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= (state == FLUSH) ? '0 : in_dout;

      if (state != FLUSH) in_count <= in_count + 1'b1;

      if (state != FILL) begin
        if (out_col == LAST_COL) begin
          out_col <= '0;
          out_row <= out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end

      case (state)
        FILL: begin
          if (in_count == LAST_READ)      state <= FLUSH;
          else if (in_count == FILL_LAST) state <= RUN;
        end
        RUN: begin
          if (in_count == LAST_READ) state <= FLUSH;
        end
        FLUSH: begin
          // Old-frame pixels stay in sr; border masking keeps them out of the next frame.
          if (out_row == LAST_ROW && out_col == LAST_COL) begin
            state    <= FILL;
            in_count <= '0;
            out_row  <= '0;
            out_col  <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
